// File: rtl/tdm_link_scheduler_if.sv
// Channel-side bundle of the TDM link scheduler: requests and words in, link bits out and back,
// reassembled words and status out.
interface tdm_link_scheduler_if #(
    parameter int unsigned W = 8
);
    logic [3:0]     req;
    logic [4*W-1:0] data_in;
    logic [3:0]     ack;
    logic [1:0]     sel;
    logic [3:0]     tx_bits;
    logic [3:0]     rx_bits;
    logic [W-1:0]   rx_data;
    logic [3:0]     rx_valid;
    logic           err;
    logic           busy;

    modport master (
        output req, data_in, rx_bits,
        input  ack, sel, tx_bits, rx_data, rx_valid, err, busy
    );

    modport slave (
        input  req, data_in, rx_bits,
        output ack, sel, tx_bits, rx_data, rx_valid, err, busy
    );
endinterface

// File: rtl/tdm_link_scheduler.sv
// Round-robin TDM scheduler for a 4:1 mux -> wire -> 1:4 demux link: grants one channel per
// frame, serializes its word MSB first, reassembles the looped-back bits and flags mismatches.
module tdm_link_scheduler #(
    parameter int unsigned W = 8
) (
    input logic                 clk,
    input logic                 rst,
    tdm_link_scheduler_if.slave bus
);
    localparam int unsigned CntW = $clog2(W);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [1:0]      last_grant_q, last_grant_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      ack_q, ack_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [W-1:0]    tx_sr_q, tx_sr_d;
    logic [W-1:0]    rx_sr_q, rx_sr_d;
    logic [W-1:0]    word_q, word_d;
    logic [W-1:0]    rx_data_q, rx_data_d;
    logic [3:0]      rx_valid_q, rx_valid_d;
    logic            err_q, err_d;

    logic            grant_found;
    logic [1:0]      grant_idx;
    logic [1:0]      cand;
    logic            rx_bit;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        cand        = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant_q + 2'(i);
            if (!grant_found && bus.req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign rx_bit = bus.rx_bits[sel_q];

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        ack_d        = '0;
        bit_cnt_d    = bit_cnt_q;
        tx_sr_d      = tx_sr_q;
        rx_sr_d      = rx_sr_q;
        word_d       = word_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = '0;
        err_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    tx_sr_d      = bus.data_in[grant_idx*W +: W];
                    word_d       = bus.data_in[grant_idx*W +: W];
                    sel_d        = grant_idx;
                    last_grant_d = grant_idx;
                    ack_d        = 4'b0001 << grant_idx;
                    bit_cnt_d    = '0;
                    state_d      = StShift;
                end
            end
            StShift: begin
                rx_sr_d   = {rx_sr_q[W-2:0], rx_bit};
                tx_sr_d   = tx_sr_q << 1;
                bit_cnt_d = bit_cnt_q + CntW'(1);
                // Results are registered on the last shift edge so they appear throughout DONE.
                if (bit_cnt_q == CntW'(W - 1)) begin
                    state_d    = StDone;
                    rx_data_d  = rx_sr_d;
                    rx_valid_d = 4'b0001 << sel_q;
                    err_d      = (rx_sr_d != word_q);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 2'd3;
            sel_q        <= '0;
            ack_q        <= '0;
            bit_cnt_q    <= '0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            word_q       <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            ack_q        <= ack_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_sr_q      <= tx_sr_d;
            rx_sr_q      <= rx_sr_d;
            word_q       <= word_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            err_q        <= err_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.sel      = sel_q;
    assign bus.tx_bits  = (state_q == StShift && tx_sr_q[W-1]) ? (4'b0001 << sel_q) : 4'b0000;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != StIdle);
endmodule

// File: tb/tb_tdm_link_scheduler.sv
// Bench for tdm_link_scheduler: frame-timeline model checked every cycle plus directed scenarios
// with literal expectations; the link is looped tx_bits -> rx_bits with optional bit flips.
module tb_tdm_link_scheduler;
    localparam int unsigned W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] flip_mask = 4'b0000;

    tdm_link_scheduler_if #(.W(W)) bus ();

    tdm_link_scheduler #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rx_bits = bus.tx_bits ^ flip_mask;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        for (int i = 1; i <= 4; i++) begin
            if (r[(int'(last) + i) % 4]) return 2'((int'(last) + i) % 4);
        end
        return last;
    endfunction

    // Model: a frame is a timeline of W+2 cycles counted from the cycle the grant is decided.
    bit           m_ok = 1'b0;
    bit           in_frame = 1'b0;
    int           cyc = 0;
    int           start = 0;
    logic [1:0]   m_last = 2'd3;
    logic [1:0]   m_sel = 2'd0;
    logic [1:0]   g = 2'd0;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_acc = '0;
    logic [W-1:0] m_rxd = '0;

    always @(negedge clk) begin
        int         p;
        logic [3:0] oh, e_ack, e_tx, e_rxv;
        logic       e_busy, e_err, b;
        cyc++;
        p      = cyc - start;
        oh     = 4'b0001 << g;
        e_ack  = '0;
        e_tx   = '0;
        e_rxv  = '0;
        e_busy = 1'b0;
        e_err  = 1'b0;
        b      = 1'b0;
        if (in_frame && p >= 1 && p <= int'(W)) begin
            e_busy = 1'b1;
            b      = m_word[int'(W) - p];
            if (p == 1) e_ack = oh;
            if (b) e_tx = oh;
        end else if (in_frame && p == int'(W) + 1) begin
            e_busy = 1'b1;
            e_rxv  = oh;
            m_rxd  = m_acc;
            e_err  = (m_acc != m_word);
        end
        if (m_ok) begin
            chk("model ack", 32'(bus.ack), 32'(e_ack));
            chk("model sel", 32'(bus.sel), 32'(m_sel));
            chk("model tx_bits", 32'(bus.tx_bits), 32'(e_tx));
            chk("model rx_valid", 32'(bus.rx_valid), 32'(e_rxv));
            chk("model rx_data", 32'(bus.rx_data), 32'(m_rxd));
            chk("model err", 32'(bus.err), 32'(e_err));
            chk("model busy", 32'(bus.busy), 32'(e_busy));
        end
        if (rst) begin
            m_ok     = 1'b1;
            in_frame = 1'b0;
            m_last   = 2'd3;
            m_sel    = 2'd0;
            m_rxd    = '0;
        end else if (in_frame) begin
            if (p >= 1 && p <= int'(W)) m_acc = {m_acc[W-2:0], b ^ flip_mask[g]};
            if (p == int'(W) + 1) in_frame = 1'b0;
        end else if (bus.req != 4'b0000) begin
            g        = rr_pick(bus.req, m_last);
            m_last   = g;
            m_sel    = g;
            m_word   = bus.data_in[g*W +: W];
            m_acc    = '0;
            start    = cyc;
            in_frame = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    initial begin
        logic [W-1:0] exp2;
        int           rv_cyc [4];
        logic [3:0]   rv_oh  [4];
        logic [W-1:0] rv_dat [4];
        int           nrx, ngr, seen;
        logic [1:0]   gr [6];
        logic [1:0]   gr_exp [6];

        bus.req     = '0;
        bus.data_in = '0;

        // 1: reset and idle
        step();
        step();
        chk("reset ack", 32'(bus.ack), 32'h0);
        chk("reset busy", 32'(bus.busy), 32'h0);
        chk("reset rx_data", 32'(bus.rx_data), 32'h0);
        chk("reset tx_bits", 32'(bus.tx_bits), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle busy", 32'(bus.busy), 32'h0);
            chk("idle sel", 32'(bus.sel), 32'h0);
        end

        // 2: single ch2 frame, word A5
        bus.data_in[2*W +: W] = 8'hA5;
        bus.req = 4'b0100;
        step();
        chk("t2 ack", 32'(bus.ack), 32'h4);
        chk("t2 sel", 32'(bus.sel), 32'h2);
        bus.req = 4'b0000;
        exp2 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk("t2 wire bit", 32'(bus.tx_bits[2]), 32'(exp2[7-i]));
            step();
        end
        chk("t2 rx_valid", 32'(bus.rx_valid), 32'h4);
        chk("t2 rx_data", 32'(bus.rx_data), 32'hA5);
        chk("t2 err", 32'(bus.err), 32'h0);
        step();
        chk("t2 busy end", 32'(bus.busy), 32'h0);

        // 3: all four requesting after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req = 4'b1111;
        nrx = 0;
        for (int k = 0; k < 4; k++) begin
            rv_cyc[k] = -1;
            rv_oh[k]  = '0;
            rv_dat[k] = '0;
        end
        for (int t = 1; t <= 45; t++) begin
            step();
            if (bus.ack != 4'b0000) bus.req = bus.req & ~bus.ack;
            if (bus.rx_valid != 4'b0000 && nrx < 4) begin
                rv_cyc[nrx] = t;
                rv_oh[nrx]  = bus.rx_valid;
                rv_dat[nrx] = bus.rx_data;
                nrx++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            chk("t3 rx cycle", 32'(rv_cyc[k]), 32'(9 + 10*k));
            chk("t3 rx channel", 32'(rv_oh[k]), 32'(4'b0001 << k));
            chk("t3 rx word", 32'(rv_dat[k]), 32'(8'h11 * (k + 1)));
        end

        // 4: channels 0 and 3 alternate
        gr_exp = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3};
        for (int k = 0; k < 6; k++) gr[k] = 2'd1;
        bus.req = 4'b1001;
        ngr = 0;
        for (int t = 0; t < 70 && ngr < 6; t++) begin
            step();
            if (bus.ack != 4'b0000) begin
                for (int c = 0; c < 4; c++) if (bus.ack[c]) gr[ngr] = 2'(c);
                ngr++;
                if (ngr == 6) bus.req = 4'b0000;
            end
        end
        for (int k = 0; k < 6; k++) chk("t4 grant order", 32'(gr[k]), 32'(gr_exp[k]));
        cycles(12);

        // 5: reset in the middle of a ch1 frame
        bus.data_in[1*W +: W] = 8'h5A;
        bus.req = 4'b0010;
        step();
        chk("t5 ack", 32'(bus.ack), 32'h2);
        bus.req = 4'b0000;
        cycles(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5 busy after rst", 32'(bus.busy), 32'h0);
        seen = 0;
        for (int t = 0; t < 12; t++) begin
            step();
            if (bus.rx_valid != 4'b0000) seen++;
        end
        chk("t5 no rx_valid", 32'(seen), 32'h0);
        bus.req = 4'b0011;
        step();
        chk("t5 first grant ch0", 32'(bus.ack), 32'h1);
        bus.req[0] = 1'b0;
        seen = 0;
        for (int t = 0; t < 20 && seen == 0; t++) begin
            step();
            if (bus.ack[1]) seen = 1;
        end
        chk("t5 ch1 granted", 32'(seen), 32'h1);
        bus.req = 4'b0000;
        cycles(12);

        // 6: corrupted first bit on the wire
        bus.data_in[0 +: W] = 8'h3C;
        bus.req = 4'b0001;
        step();
        chk("t6 ack", 32'(bus.ack), 32'h1);
        bus.req = 4'b0000;
        flip_mask = 4'b0001;
        step();
        flip_mask = 4'b0000;
        cycles(7);
        chk("t6 rx_valid", 32'(bus.rx_valid), 32'h1);
        chk("t6 rx_data", 32'(bus.rx_data), 32'hBC);
        chk("t6 err", 32'(bus.err), 32'h1);
        step();
        chk("t6 busy end", 32'(bus.busy), 32'h0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
